// File: rtl/event_capture_arbiter.sv
// Round-robin arbiter that pops one event word at a time from several source FIFOs,
// filters out-of-frame coordinates and hands in-frame events to the convolution stage.
module event_capture_arbiter #(
    parameter int NUM_SOURCES = 4,
    parameter int COORD_BITS  = 8,
    parameter int IMG_WIDTH   = 32,
    parameter int IMG_HEIGHT  = 32,
    parameter int CNT_BITS    = 16,
    localparam int SRC_BITS   = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                enable,
    input  logic [NUM_SOURCES-1:0]              fifo_empty,
    output logic [NUM_SOURCES-1:0]              fifo_read_en,
    input  logic [NUM_SOURCES*2*COORD_BITS-1:0] fifo_read_data,
    output logic                                event_valid,
    input  logic                                event_ready,
    input  logic                                event_ack,
    output logic [COORD_BITS-1:0]               event_x,
    output logic [COORD_BITS-1:0]               event_y,
    output logic [SRC_BITS-1:0]                 event_source,
    output logic                                active,
    output logic [CNT_BITS-1:0]                 accept_count,
    output logic [CNT_BITS-1:0]                 drop_count
);

    localparam int WORD = 2 * COORD_BITS;
    localparam logic [31:0] X_LIMIT = 32'(IMG_WIDTH);
    localparam logic [31:0] Y_LIMIT = 32'(IMG_HEIGHT);
    localparam logic [SRC_BITS-1:0] LAST_SRC = SRC_BITS'(NUM_SOURCES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        LATCH   = 2'd2,
        PRESENT = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [SRC_BITS-1:0]   grant_q, grant_d;
    logic [SRC_BITS-1:0]   rrPtr_q, rrPtr_d;
    logic [COORD_BITS-1:0] x_q, x_d;
    logic [COORD_BITS-1:0] y_q, y_d;
    logic [CNT_BITS-1:0]   accept_q, accept_d;
    logic [CNT_BITS-1:0]   drop_q, drop_d;

    logic [WORD-1:0]       words [NUM_SOURCES];
    logic [WORD-1:0]       selWord;
    logic [COORD_BITS-1:0] selX;
    logic [COORD_BITS-1:0] selY;
    logic                  inFrame;
    logic                  found;
    logic [SRC_BITS-1:0]   pick;
    logic [SRC_BITS-1:0]   pickNext;

    for (genvar gi = 0; gi < NUM_SOURCES; gi++) begin : g_unpack
        assign words[gi] = fifo_read_data[gi*WORD +: WORD];
    end

    assign selWord = words[grant_q];
    assign selX    = selWord[WORD-1:COORD_BITS];
    assign selY    = selWord[COORD_BITS-1:0];
    assign inFrame = (32'(selX) < X_LIMIT) && (32'(selY) < Y_LIMIT);

    // Scan upward from the round-robin pointer, wrapping, for the first non-empty source.
    always_comb begin
        int                  idxFull;
        logic [SRC_BITS-1:0] idx;
        found   = 1'b0;
        pick    = '0;
        idxFull = 0;
        idx     = '0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            idxFull = int'(rrPtr_q) + i;
            if (idxFull >= NUM_SOURCES) begin
                idxFull = idxFull - NUM_SOURCES;
            end
            idx = SRC_BITS'(idxFull);
            if (!found && !fifo_empty[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign pickNext = (pick == LAST_SRC) ? '0 : pick + SRC_BITS'(1);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rrPtr_d      = rrPtr_q;
        x_d          = x_q;
        y_d          = y_q;
        accept_d     = accept_q;
        drop_d       = drop_q;
        fifo_read_en = '0;

        case (state_q)
            IDLE: begin
                if (enable && event_ready && found) begin
                    grant_d = pick;
                    rrPtr_d = pickNext;
                    state_d = READ;
                end
            end
            READ: begin
                fifo_read_en[grant_q] = 1'b1;
                state_d               = LATCH;
            end
            LATCH: begin
                x_d = selX;
                y_d = selY;
                if (inFrame) begin
                    state_d = PRESENT;
                end else begin
                    if (drop_q != '1) begin
                        drop_d = drop_q + CNT_BITS'(1);
                    end
                    state_d = IDLE;
                end
            end
            PRESENT: begin
                if (event_ack) begin
                    if (accept_q != '1) begin
                        accept_d = accept_q + CNT_BITS'(1);
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rrPtr_q  <= '0;
            x_q      <= '0;
            y_q      <= '0;
            accept_q <= '0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rrPtr_q  <= rrPtr_d;
            x_q      <= x_d;
            y_q      <= y_d;
            accept_q <= accept_d;
            drop_q   <= drop_d;
        end
    end

    assign event_valid  = (state_q == PRESENT);
    assign active       = (state_q != IDLE);
    assign event_x      = x_q;
    assign event_y      = y_q;
    assign event_source = grant_q;
    assign accept_count = accept_q;
    assign drop_count   = drop_q;

endmodule

// File: doc/event_capture_arbiter.md
EVENT_CAPTURE_ARBITER -- requirements
Module: event_capture_arbiter

Interface
REQ-001 Parameter NUM_SOURCES, default 4, number of input event FIFOs (1..16).
REQ-002 Parameter COORD_BITS, default 8, bits per coordinate; FIFO word = 2*COORD_BITS, x in upper half, y in lower half.
REQ-003 Parameter IMG_WIDTH, default 32, exclusive x bound.
REQ-004 Parameter IMG_HEIGHT, default 32, exclusive y bound.
REQ-005 Parameter CNT_BITS, default 16, width of statistics counters.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 enable  input  1  permits starting new FIFO reads.
REQ-009 fifo_empty  input  NUM_SOURCES  per-source FIFO empty flag.
REQ-010 fifo_read_en  output  NUM_SOURCES  per-source pop strobe, one-hot or zero.
REQ-011 fifo_read_data  input  NUM_SOURCES*2*COORD_BITS  per-source FIFO output word; source i at bits [i*2*COORD_BITS +: 2*COORD_BITS]; valid one cycle after read_en.
REQ-012 event_valid  output  1  event presented to convolution.
REQ-013 event_ready  input  1  convolution can accept a new event.
REQ-014 event_ack  input  1  convolution has taken the presented event.
REQ-015 event_x, event_y  output  COORD_BITS each  presented coordinates.
REQ-016 event_source  output  max(1,clog2(NUM_SOURCES))  index of originating FIFO.
REQ-017 active  output  1  high whenever state is not IDLE.
REQ-018 accept_count, drop_count  output  CNT_BITS each  acknowledged / discarded event totals.

Function
REQ-019 FSM states IDLE, READ, LATCH, PRESENT; exactly one active.
REQ-020 IDLE: when enable=1, event_ready=1 and any fifo_empty bit =0, register grant = first non-empty source searching upward from rr_ptr with wrap; go READ; else stay.
REQ-021 READ: fifo_read_en[grant]=1 for exactly this one cycle; all other bits 0; go LATCH.
REQ-022 LATCH: register x, y from fifo_read_data slice of grant; if x<IMG_WIDTH and y<IMG_HEIGHT go PRESENT, else increment drop_count and go IDLE.
REQ-023 PRESENT: event_valid=1, event_x/event_y/event_source stable; on event_ack=1 increment accept_count and go IDLE.
REQ-024 event_ack outside PRESENT is ignored; event_ready is sampled only in IDLE.
REQ-025 Latency: READ to event_valid high = 2 cycles; IDLE decision to event_valid = 3 cycles; back-to-back throughput one event per 4 cycles minimum.
REQ-026 rr_ptr updates on entry to READ to (grant+1) mod NUM_SOURCES; a source just served has lowest priority next arbitration.
REQ-027 NUM_SOURCES=1: arbitration degenerates to source 0, event_source=0.
REQ-028 enable deasserted mid-transaction: current READ/LATCH/PRESENT completes; no new grant until enable=1.
REQ-029 Counters saturate at 2^CNT_BITS-1; no wrap.
REQ-030 fifo_read_en never asserted to a source whose fifo_empty was 1 at grant time.
REQ-031 event_valid low in all states other than PRESENT.

Reset
REQ-032 reset=1 at a rising edge: state=IDLE, rr_ptr=0, fifo_read_en=0, event_valid=0, event_x=event_y=0, event_source=0, active=0, accept_count=drop_count=0.
REQ-033 reset overrides all inputs; reset during READ or LATCH discards the popped word without counting it.

Verification
REQ-034 Source 0 holds (5,10), others empty, enable=1, ready=1 -> read_en=0001 for one cycle, event_valid 2 cycles later with x=5,y=10,source=0; ack -> accept_count=1, IDLE.
REQ-035 All 4 sources non-empty, one word each, ack immediately every PRESENT -> grant order 0,1,2,3; second round begins at source 0 after rr wrap.
REQ-036 Source 2 holds (40,3) with IMG_WIDTH=32 -> no event_valid, drop_count=1, state returns to IDLE; following (31,31) presented normally.
REQ-037 Event presented, event_ack held 0 for 10 cycles -> event_valid and coordinates stable all 10 cycles, no read_en; ack on cycle 11 -> accept_count increments once.
REQ-038 event_ready=0 with non-empty FIFOs -> no read_en for duration; ready=1 -> grant next cycle.
REQ-039 reset pulsed while in PRESENT with accept_count=3 -> next cycle all outputs at REQ-032 values, event_valid=0, counters 0.
